// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith ops, radix-2 multi-cycle MUL and DIV.
// Define ALU_ITER_DIV_EN to build the restoring divider; otherwise op 9 is illegal.
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             out_err
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

    typedef enum logic [1:0] { IDLE, MUL, DIV, FIX } state_t;

    state_t             state;
    state_t             state_nx;
    logic [SW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   mcand;
    logic               neg_lo;

    logic               accept;
    logic               go_mul;
    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [SW-1:0]      shamt;
    logic [WIDTH-1:0]   alu_lo;
    logic [WIDTH-1:0]   alu_hi;
    logic               alu_err;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;

`ifdef ALU_ITER_DIV_EN
    logic               neg_hi;
    logic               is_div;
    logic               go_div;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH-1:0]   div_df;
    logic               div_ge;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
`endif

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign go_mul   = accept && (op == 4'd8);
    assign sgn_a    = is_signed && opa[WIDTH-1];
    assign sgn_b    = is_signed && opb[WIDTH-1];
    assign mag_a    = sgn_a ? -opa : opa;
    assign mag_b    = sgn_b ? -opb : opb;
    assign shamt    = opb[SW-1:0];

    // Shift-add: {acc,mq} shifts right one bit per cycle, mq holds multiplier.
    assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
    assign prod    = neg_lo ? -{acc, mq} : {acc, mq};

`ifdef ALU_ITER_DIV_EN
    assign go_div = accept && (op == 4'd9) && (opb != '0);
    assign div_sh = {acc, mq[WIDTH-1]};
    assign div_ge = div_sh >= {1'b0, mcand};
    assign div_df = div_sh[WIDTH-1:0] - mcand;
    assign quo    = neg_lo ? -mq : mq;
    assign rem    = neg_hi ? -acc : acc;
`endif

    always_comb begin
        alu_lo  = '0;
        alu_hi  = '0;
        alu_err = 1'b0;
        unique case (op)
            4'd0: alu_lo = opa + opb;
            4'd1: alu_lo = opa - opb;
            4'd2: alu_lo = opa & opb;
            4'd3: alu_lo = opa | opb;
            4'd4: alu_lo = opa ^ opb;
            4'd5: alu_lo = opa << shamt;
            4'd6: alu_lo = opa >> shamt;
            4'd7: alu_lo = $signed(opa) >>> shamt;
`ifdef ALU_ITER_DIV_EN
            4'd9: begin
                alu_lo  = '1;
                alu_hi  = opa;
                alu_err = 1'b1;
            end
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (go_mul) state_nx = MUL;
`ifdef ALU_ITER_DIV_EN
                if (go_div) state_nx = DIV;
`endif
            end
            MUL, DIV: if (cnt == LAST) state_nx = FIX;
            FIX:      state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) state <= IDLE;
        else           state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            cnt       <= '0;
            acc       <= '0;
            mq        <= '0;
            mcand     <= '0;
            neg_lo    <= 1'b0;
            out       <= '0;
            out_hi    <= '0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_ITER_DIV_EN
            neg_hi    <= 1'b0;
            is_div    <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    cnt <= '0;
                    if (go_mul) begin
                        acc    <= '0;
                        mq     <= mag_a;
                        mcand  <= mag_b;
                        neg_lo <= sgn_a ^ sgn_b;
`ifdef ALU_ITER_DIV_EN
                        is_div <= 1'b0;
                    end else if (go_div) begin
                        acc    <= '0;
                        mq     <= mag_a;
                        mcand  <= mag_b;
                        neg_lo <= sgn_a ^ sgn_b;
                        neg_hi <= sgn_a;
                        is_div <= 1'b1;
`endif
                    end else begin
                        out       <= alu_lo;
                        out_hi    <= alu_hi;
                        out_err   <= alu_err;
                        out_valid <= 1'b1;
                    end
                end
                MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
`ifdef ALU_ITER_DIV_EN
                    acc <= div_ge ? div_df : div_sh[WIDTH-1:0];
                    mq  <= {mq[WIDTH-2:0], div_ge};
                    cnt <= cnt + 1'b1;
`endif
                end
                FIX: begin
                    out_err   <= 1'b0;
                    out_valid <= 1'b1;
`ifdef ALU_ITER_DIV_EN
                    if (is_div) begin
                        out    <= quo;
                        out_hi <= rem;
                    end else begin
                        out    <= prod[WIDTH-1:0];
                        out_hi <= prod[2*WIDTH-1:WIDTH];
                    end
`else
                    out    <= prod[WIDTH-1:0];
                    out_hi <= prod[2*WIDTH-1:WIDTH];
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_async  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request present.
REQ-005 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-006 SHALL have port op  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL, 9 DIV, 10-15 illegal.
REQ-007 SHALL have port is_signed  input  1  signed operands for MUL/DIV; ignored for other ops.
REQ-008 SHALL have ports opa, opb  input  WIDTH  operands.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have ports out, out_hi  output  WIDTH  result: low word/quotient and high word/remainder.
REQ-012 SHALL have port out_err  output  1  illegal op or divide by zero.

Function
REQ-013 SHALL accept a request on a clock edge where in_valid && in_ready; opa, opb, op and is_signed are captured.
REQ-014 SHALL drive in_ready = (state == IDLE) && (!out_valid || out_ready).
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, FIX. IDLE->MUL on MUL accept; IDLE->DIV on DIV accept with opb != 0; MUL/DIV->FIX after WIDTH iteration cycles; FIX->IDLE.
REQ-016 SHALL produce ops 0-7 in one cycle: out_valid is high after the accept edge; out_hi = 0.
REQ-017 SHALL use shift amount opb[log2(WIDTH)-1:0]; SRA SHALL replicate opa[WIDTH-1].
REQ-018 SHALL compute ADD/SUB modulo 2^WIDTH; carry and overflow SHALL be discarded.
REQ-019 SHALL implement MUL as radix-2 shift-add on operand magnitudes, one bit per cycle; the FIX cycle applies the sign; {out_hi,out} = the full 2*WIDTH product.
REQ-020 SHALL implement DIV as radix-2 restoring division on magnitudes; quotient sign = sign(opa)^sign(opb); remainder sign = sign(opa).
REQ-021 SHALL give MUL/DIV a latency of WIDTH+1 edges after accept: out_valid rises on edge accept+WIDTH+1.
REQ-022 SHALL, on DIV with opb == 0, give out = all-ones, out_hi = opa, out_err = 1, with one-cycle latency and no entry to DIV.
REQ-023 SHALL, on signed DIV of the most negative value by -1, give out = the most negative value, out_hi = 0, out_err = 0.
REQ-024 SHALL, on an illegal op, give out = 0, out_hi = 0, out_err = 1, with one-cycle latency.
REQ-025 SHALL hold out, out_hi, out_err and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL clear out_valid on an out_ready edge unless a new result is written on the same edge; back-to-back single-cycle ops SHALL sustain one result per cycle.
REQ-027 SHALL ignore in_valid while in MUL, DIV or FIX; in_ready is low in those states.

Reset
REQ-028 SHALL, on rst_async high, immediately set state = IDLE, out_valid = 0, out = 0, out_hi = 0, out_err = 0, and clear the iteration counter and working registers.
REQ-029 SHALL abandon an in-progress MUL/DIV on reset, with no result emitted; in_ready SHALL be high on the first edge after reset deasserts.

Configuration
REQ-030 SHALL use macro ALU_ITER_DIV_EN: when defined, DIV and the DIV state are implemented per REQ-020 to REQ-023; when undefined, op 9 is treated as illegal per REQ-024 and no divider logic is synthesised.

Verification (WIDTH=32)
REQ-031 SHALL cover ADD 0xFFFFFFFF+1, then SRA 0x80000000 by 0x24 back-to-back with out_ready=1 -> results 0x00000000, then 0xF8000000, on consecutive cycles.
REQ-032 SHALL cover signed MUL -3 * 7 -> after 33 edges out=0xFFFFFFEB, out_hi=0xFFFFFFFF; unsigned 0xFFFFFFFF * 2 -> out=0xFFFFFFFE, out_hi=0x00000001.
REQ-033 SHALL cover signed DIV -7 / 2 -> out=0xFFFFFFFD, out_hi=0xFFFFFFFF; DIV 5 / 0 -> out=0xFFFFFFFF, out_hi=5, out_err=1 after 1 edge.
REQ-034 SHALL cover out_ready held low for 5 cycles after ADD 2+3 -> out=5 stable, in_ready=0 throughout; release -> out_valid falls on the next edge.
REQ-035 SHALL cover rst_async pulsed during MUL iteration 10 -> outputs 0 immediately, no out_valid afterwards, and a new ADD accepted on the first edge after release.
REQ-036 SHALL cover op=12 -> out_err=1, out=0; and with ALU_ITER_DIV_EN undefined, op=9 -> out_err=1.
